// File: rtl/conbus_rr_pkg.sv
// Shared types, default slot map and sizing helper for the round-robin
// Wishbone shared-bus interconnect.
package conbus_rr_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_END     = 3'b111
  } cti_e;

  localparam int          DEF_NS       = 6;
  localparam int          DEF_S_ADDR_W = 3;
  // Slot 0 in the LSBs: BRAM 000, 001, SRAM 010, 100, 101, 110
  localparam logic [17:0] DEF_S_ADDR   = {3'b110, 3'b101, 3'b100, 3'b010, 3'b001, 3'b000};
  localparam logic [5:0]  DEF_S_EN     = 6'b111111;

  // Index width that never collapses to zero bits
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conbus_rr_arb.sv
// Registered round-robin arbiter: one-hot grant held until the owner
// releases, then one idle cycle before the next search.
module conbus_rr_arb
  import conbus_rr_pkg::*;
#(
  parameter int NM = 6
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [NM-1:0]          req,
  input  logic                   rel,
  output logic [NM-1:0]          grant,
  output logic [idx_w(NM)-1:0]   grant_idx,
  output logic                   busy
);

  localparam int MW = idx_w(NM);

  logic [MW-1:0] idx_r;
  logic [MW-1:0] pick_s;
  logic [MW-1:0] cand_s;
  logic [NM-1:0] grant_r;
  logic          busy_r;
  logic          found_s;

  // Rotating-priority search starting one past the last owner
  always_comb begin
    pick_s  = idx_r;
    found_s = 1'b0;
    cand_s  = idx_r;
    for (int i = 1; i <= NM; i++) begin
      cand_s = MW'((int'(idx_r) + i) % NM);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        pick_s  = pick_s;
      end
    end
  end

  // Grant register: drop on release, latch a new owner only from idle
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      busy_r  <= 1'b0;
      idx_r   <= MW'(NM - 1);
      grant_r <= '0;
    end else if (busy_r) begin
      if (rel) begin
        busy_r  <= 1'b0;
        grant_r <= '0;
      end
    end else if (found_s) begin
      busy_r  <= 1'b1;
      idx_r   <= pick_s;
      grant_r <= {{(NM-1){1'b0}}, 1'b1} << pick_s;
    end
  end

  assign grant     = grant_r;
  assign grant_idx = idx_r;
  assign busy      = busy_r;

endmodule

// File: rtl/conbus_rr.sv
// Parametrised Wishbone shared-bus interconnect with registered round-robin
// arbitration, address decode, unmapped-slot error responder and watchdog.
module conbus_rr
  import conbus_rr_pkg::*;
#(
  parameter int                     NM       = 6,
  parameter int                     NS       = DEF_NS,
  parameter int                     ADR_W    = 32,
  parameter int                     DAT_W    = 32,
  parameter int                     S_ADDR_W = DEF_S_ADDR_W,
  parameter logic [NS*S_ADDR_W-1:0] S_ADDR   = DEF_S_ADDR,
  parameter logic [NS-1:0]          S_EN     = DEF_S_EN,
  parameter int                     TIMEOUT  = 255
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [NM*ADR_W-1:0]       m_adr_i,
  input  logic [NM*DAT_W-1:0]       m_dat_i,
  input  logic [NM*(DAT_W/8)-1:0]   m_sel_i,
  input  logic [NM*3-1:0]           m_cti_i,
  input  logic [NM-1:0]             m_we_i,
  input  logic [NM-1:0]             m_cyc_i,
  input  logic [NM-1:0]             m_stb_i,
  output logic [DAT_W-1:0]          m_dat_o,
  output logic [NM-1:0]             m_ack_o,
  output logic [NM-1:0]             m_err_o,
  output logic [ADR_W-1:0]          s_adr_o,
  output logic [DAT_W-1:0]          s_dat_o,
  output logic [DAT_W/8-1:0]        s_sel_o,
  output logic [2:0]                s_cti_o,
  output logic                      s_we_o,
  output logic [NS-1:0]             s_cyc_o,
  output logic [NS-1:0]             s_stb_o,
  input  logic [NS*DAT_W-1:0]       s_dat_i,
  input  logic [NS-1:0]             s_ack_i,
  input  logic [NS-1:0]             s_err_i,
  output logic [NM-1:0]             grant_o
);

  localparam int SEL_W = DAT_W / 8;
  localparam int MW    = idx_w(NM);
  localparam int WD_W  = idx_w(TIMEOUT + 1) + 1;
  localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic             busy_s;
  logic [NM-1:0]    grant_s;
  logic [MW-1:0]    gidx_s;
  logic [ADR_W-1:0] g_adr_s;
  logic [DAT_W-1:0] g_dat_s;
  logic [SEL_W-1:0] g_sel_s;
  logic [2:0]       g_cti_s;
  logic             g_we_s;
  logic             g_cyc_s;
  logic             g_stb_s;
  logic [NS-1:0]    hit_s;
  logic             any_hit_s;
  logic [DAT_W-1:0] hit_dat_s;
  logic             hit_ack_s;
  logic             hit_err_s;
  logic             wd_fire_s;
  logic             ack_s;
  logic             err_s;
  logic             ue_r;
  logic             ue_gap_r;
  logic [WD_W-1:0]  wd_cnt_r;

  conbus_rr_arb #(
    .NM (NM)
  ) u_arb (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (m_cyc_i),
    .rel       (~g_cyc_s),
    .grant     (grant_s),
    .grant_idx (gidx_s),
    .busy      (busy_s)
  );

  // Granted-master field mux (AND-OR over the registered index)
  always_comb begin
    g_adr_s = '0;
    g_dat_s = '0;
    g_sel_s = '0;
    g_cti_s = 3'b000;
    g_we_s  = 1'b0;
    g_cyc_s = 1'b0;
    g_stb_s = 1'b0;
    for (int i = 0; i < NM; i++) begin
      g_adr_s = g_adr_s | (m_adr_i[i*ADR_W +: ADR_W] & {ADR_W{gidx_s == MW'(i)}});
      g_dat_s = g_dat_s | (m_dat_i[i*DAT_W +: DAT_W] & {DAT_W{gidx_s == MW'(i)}});
      g_sel_s = g_sel_s | (m_sel_i[i*SEL_W +: SEL_W] & {SEL_W{gidx_s == MW'(i)}});
      g_cti_s = g_cti_s | (m_cti_i[i*3 +: 3] & {3{gidx_s == MW'(i)}});
      g_we_s  = g_we_s  | (m_we_i[i]  & (gidx_s == MW'(i)));
      g_cyc_s = g_cyc_s | (m_cyc_i[i] & (gidx_s == MW'(i)));
      g_stb_s = g_stb_s | (m_stb_i[i] & (gidx_s == MW'(i)));
    end
  end

  // Lowest-index populated slot whose prefix matches the granted address
  always_comb begin
    hit_s     = '0;
    any_hit_s = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (!any_hit_s && S_EN[k] &&
          (g_adr_s[ADR_W-1 -: S_ADDR_W] == S_ADDR[k*S_ADDR_W +: S_ADDR_W])) begin
        any_hit_s = 1'b1;
        hit_s[k]  = 1'b1;
      end else begin
        any_hit_s = any_hit_s;
      end
    end
  end

  // Return-path mux from the selected slot
  always_comb begin
    hit_dat_s = '0;
    hit_ack_s = 1'b0;
    hit_err_s = 1'b0;
    for (int k = 0; k < NS; k++) begin
      hit_dat_s = hit_dat_s | (s_dat_i[k*DAT_W +: DAT_W] & {DAT_W{hit_s[k]}});
      hit_ack_s = hit_ack_s | (s_ack_i[k] & hit_s[k]);
      hit_err_s = hit_err_s | (s_err_i[k] & hit_s[k]);
    end
  end

  // Timeout only fires on a strobe the slave is not answering this cycle
  assign wd_fire_s = (TIMEOUT != 0) && busy_s && g_stb_s && !ue_r &&
                     !hit_ack_s && !hit_err_s && (wd_cnt_r == WD_LAST);
  assign err_s     = busy_s & (ue_r | wd_fire_s | (g_stb_s & hit_err_s));
  assign ack_s     = busy_s & g_stb_s & hit_ack_s & ~hit_err_s & ~wd_fire_s;

  assign s_cyc_o = hit_s & {NS{busy_s & g_cyc_s & ~wd_fire_s}};
  assign s_stb_o = hit_s & {NS{busy_s & g_stb_s & ~wd_fire_s}};
  assign s_adr_o = g_adr_s;
  assign s_dat_o = g_dat_s;
  assign s_sel_o = g_sel_s;
  assign s_cti_o = g_cti_s;
  assign s_we_o  = g_we_s;
  assign m_dat_o = hit_dat_s;
  assign m_ack_o = grant_s & {NM{ack_s}};
  assign m_err_o = grant_s & {NM{err_s}};
  assign grant_o = grant_s;

  // Unmapped-slot responder: one-cycle error, then a mandatory quiet cycle
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ue_r     <= 1'b0;
      ue_gap_r <= 1'b0;
    end else begin
      ue_r     <= busy_s & g_stb_s & ~any_hit_s & ~ue_r & ~ue_gap_r;
      ue_gap_r <= ue_r;
    end
  end

  // Per-transaction watchdog on an unanswered strobe
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wd_cnt_r <= '0;
    end else if ((TIMEOUT == 0) || !busy_s || !g_stb_s || ack_s || err_s) begin
      wd_cnt_r <= '0;
    end else begin
      wd_cnt_r <= wd_cnt_r + WD_ONE;
    end
  end

endmodule

// File: tb/tb_conbus_rr.sv
// Directed self-checking bench for conbus_rr: 3 masters, 6 slots, slot 1
// unpopulated, watchdog of 8 cycles.
module tb_conbus_rr;
  import conbus_rr_pkg::*;

  localparam int NM = 3;
  localparam int NS = 6;

  logic              sys_clk;
  logic              sys_rst_n;
  logic [NM*32-1:0]  m_adr_i;
  logic [NM*32-1:0]  m_dat_i;
  logic [NM*4-1:0]   m_sel_i;
  logic [NM*3-1:0]   m_cti_i;
  logic [NM-1:0]     m_we_i;
  logic [NM-1:0]     m_cyc_i;
  logic [NM-1:0]     m_stb_i;
  logic [31:0]       m_dat_o;
  logic [NM-1:0]     m_ack_o;
  logic [NM-1:0]     m_err_o;
  logic [31:0]       s_adr_o;
  logic [31:0]       s_dat_o;
  logic [3:0]        s_sel_o;
  logic [2:0]        s_cti_o;
  logic              s_we_o;
  logic [NS-1:0]     s_cyc_o;
  logic [NS-1:0]     s_stb_o;
  logic [NS*32-1:0]  s_dat_i;
  logic [NS-1:0]     s_ack_i;
  logic [NS-1:0]     s_err_i;
  logic [NM-1:0]     grant_o;

  int n_checks = 0;
  int n_fail   = 0;

  conbus_rr #(
    .NM       (NM),
    .NS       (NS),
    .ADR_W    (32),
    .DAT_W    (32),
    .S_ADDR_W (3),
    .S_ADDR   (DEF_S_ADDR),
    .S_EN     (6'b111101),
    .TIMEOUT  (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .m_adr_i   (m_adr_i),
    .m_dat_i   (m_dat_i),
    .m_sel_i   (m_sel_i),
    .m_cti_i   (m_cti_i),
    .m_we_i    (m_we_i),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_cti_o   (s_cti_o),
    .s_we_o    (s_we_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .grant_o   (grant_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic set_m(input logic [1:0] mi, input logic cyc, input logic stb,
                       input logic [31:0] adr, input logic [2:0] cti,
                       input logic we, input logic [31:0] dat);
    m_cyc_i[mi]         = cyc;
    m_stb_i[mi]         = stb;
    m_adr_i[mi*32 +: 32] = adr;
    m_cti_i[mi*3 +: 3]   = cti;
    m_we_i[mi]          = we;
    m_dat_i[mi*32 +: 32] = dat;
    m_sel_i[mi*4 +: 4]   = 4'hF;
  endtask

  task automatic set_s(input logic [2:0] k, input logic ack, input logic err,
                       input logic [31:0] dat);
    s_ack_i[k]          = ack;
    s_err_i[k]          = err;
    s_dat_i[k*32 +: 32] = dat;
  endtask

  initial begin
    int em;
    logic [2:0] cti_v;

    // Reset with every request and response line high: nothing may leak out
    sys_rst_n = 1'b0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_cti_i = '0; m_we_i = '0;
    m_cyc_i = 3'b111; m_stb_i = 3'b111;
    s_dat_i = '0; s_ack_i = 6'h3F; s_err_i = 6'h3F;
    tick();
    tick();
    check_eq("rst_grant", 64'(grant_o), 64'(3'b000));
    check_eq("rst_scyc",  64'(s_cyc_o), 64'(6'b000000));
    check_eq("rst_sstb",  64'(s_stb_o), 64'(6'b000000));
    check_eq("rst_ack",   64'(m_ack_o), 64'(3'b000));
    check_eq("rst_err",   64'(m_err_o), 64'(3'b000));
    m_cyc_i = '0; m_stb_i = '0; s_ack_i = '0; s_err_i = '0;
    sys_rst_n = 1'b1;

    // Single read from master 0 to slot 0, ack in the second bus cycle
    set_m(2'd0, 1'b1, 1'b1, 32'h0000_0010, CTI_CLASSIC, 1'b0, 32'h0);
    tick();
    check_eq("t1_grant", 64'(grant_o), 64'(3'b001));
    check_eq("t1_scyc",  64'(s_cyc_o), 64'(6'b000001));
    check_eq("t1_sstb",  64'(s_stb_o), 64'(6'b000001));
    check_eq("t1_sadr",  64'(s_adr_o), 64'(32'h0000_0010));
    check_eq("t1_noack", 64'(m_ack_o), 64'(3'b000));
    set_s(3'd0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    #1;
    check_eq("t1_ack",   64'(m_ack_o), 64'(3'b001));
    check_eq("t1_dat",   64'(m_dat_o), 64'(32'hDEAD_BEEF));
    tick();
    set_m(2'd0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC, 1'b0, 32'h0);
    set_s(3'd0, 1'b0, 1'b0, 32'h0);
    #1;
    check_eq("t1_rel_scyc", 64'(s_cyc_o), 64'(6'b000000));
    tick();
    check_eq("t1_idle", 64'(grant_o), 64'(3'b000));

    // Three masters contend; reset first so master 0 is granted first
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    for (int i = 0; i < NM; i++)
      set_m(2'(i), 1'b1, 1'b1, 32'h100 * (i + 1), CTI_CLASSIC, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      em = k % 3;
      tick();
      check_eq("rr_grant", 64'(grant_o), 64'(3'b001 << em));
      check_eq("rr_sadr",  64'(s_adr_o), 64'(32'h100 * (em + 1)));
      set_s(3'd0, 1'b1, 1'b0, 32'h0);
      #1;
      check_eq("rr_ack", 64'(m_ack_o), 64'(3'b001 << em));
      tick();
      set_m(2'(em), 1'b0, 1'b0, 32'h0, CTI_CLASSIC, 1'b0, 32'h0);
      set_s(3'd0, 1'b0, 1'b0, 32'h0);
      tick();
      check_eq("rr_idle", 64'(grant_o), 64'(3'b000));
      if (k < 3)
        set_m(2'(em), 1'b1, 1'b1, 32'h100 * (em + 1), CTI_CLASSIC, 1'b0, 32'h0);
    end

    // Master 1 write burst to SRAM while master 0 waits
    set_m(2'd0, 1'b1, 1'b1, 32'h0000_0100, CTI_CLASSIC, 1'b0, 32'h0);
    set_m(2'd2, 1'b0, 1'b0, 32'h0, CTI_CLASSIC, 1'b0, 32'h0);
    set_m(2'd1, 1'b1, 1'b1, 32'h4000_0000, CTI_INCR, 1'b1, 32'hA0);
    tick();
    for (int b = 0; b < 4; b++) begin
      cti_v = (b == 3) ? CTI_END : CTI_INCR;
      set_m(2'd1, 1'b1, 1'b1, 32'h4000_0000 + 32'(4 * b), cti_v, 1'b1, 32'hA0 + 32'(b));
      set_s(3'd2, 1'b1, 1'b0, 32'h1000 + 32'(b));
      #1;
      check_eq("bu_grant", 64'(grant_o), 64'(3'b010));
      check_eq("bu_scyc",  64'(s_cyc_o), 64'(6'b000100));
      check_eq("bu_cti",   64'(s_cti_o), 64'(cti_v));
      check_eq("bu_we",    64'(s_we_o),  64'(1'b1));
      check_eq("bu_sdat",  64'(s_dat_o), 64'(32'hA0 + 32'(b)));
      check_eq("bu_ack",   64'(m_ack_o), 64'(3'b010));
      check_eq("bu_mdat",  64'(m_dat_o), 64'(32'h1000 + 32'(b)));
      tick();
    end
    set_m(2'd1, 1'b0, 1'b0, 32'h0, CTI_CLASSIC, 1'b0, 32'h0);
    set_s(3'd2, 1'b0, 1'b0, 32'h0);
    #1;
    check_eq("bu_hold", 64'(grant_o), 64'(3'b010));
    tick();
    check_eq("bu_idle", 64'(grant_o), 64'(3'b000));
    tick();
    check_eq("bu_next", 64'(grant_o), 64'(3'b001));
    set_m(2'd0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC, 1'b0, 32'h0);
    tick();

    // Unmapped slot 1 from master 2: one error pulse, one cycle after stb
    set_m(2'd2, 1'b1, 1'b1, 32'h2000_0000, CTI_CLASSIC, 1'b0, 32'h0);
    tick();
    check_eq("um_grant", 64'(grant_o), 64'(3'b100));
    check_eq("um_scyc",  64'(s_cyc_o), 64'(6'b000000));
    check_eq("um_err0",  64'(m_err_o), 64'(3'b000));
    tick();
    check_eq("um_err1",  64'(m_err_o), 64'(3'b100));
    tick();
    check_eq("um_err2",  64'(m_err_o), 64'(3'b000));
    set_m(2'd2, 1'b0, 1'b0, 32'h0, CTI_CLASSIC, 1'b0, 32'h0);
    tick();

    // Slot 4 never answers: error in the 8th strobe cycle, strobe masked
    set_m(2'd1, 1'b1, 1'b1, 32'hA000_0000, CTI_CLASSIC, 1'b0, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c < 8) begin
        check_eq("wd_noerr", 64'(m_err_o), 64'(3'b000));
        check_eq("wd_sstb",  64'(s_stb_o), 64'(6'b010000));
      end else begin
        check_eq("wd_err",   64'(m_err_o), 64'(3'b010));
        check_eq("wd_mask",  64'(s_stb_o), 64'(6'b000000));
        check_eq("wd_mcyc",  64'(s_cyc_o), 64'(6'b000000));
      end
    end
    tick();
    set_m(2'd1, 1'b1, 1'b0, 32'hA000_0000, CTI_CLASSIC, 1'b0, 32'h0);
    set_s(3'd4, 1'b1, 1'b0, 32'h0);
    #1;
    check_eq("wd_late_ack", 64'(m_ack_o), 64'(3'b000));
    check_eq("wd_late_err", 64'(m_err_o), 64'(3'b000));
    tick();
    set_m(2'd1, 1'b0, 1'b0, 32'h0, CTI_CLASSIC, 1'b0, 32'h0);
    set_s(3'd4, 1'b0, 1'b0, 32'h0);
    tick();

    // Master 2 burst with ack+err collision, then reset mid-burst
    set_m(2'd0, 1'b1, 1'b1, 32'h0000_0100, CTI_CLASSIC, 1'b0, 32'h0);
    set_m(2'd2, 1'b1, 1'b1, 32'h4000_0000, CTI_INCR, 1'b0, 32'h0);
    tick();
    check_eq("rb_grant", 64'(grant_o), 64'(3'b100));
    set_s(3'd2, 1'b1, 1'b0, 32'h55);
    #1;
    check_eq("rb_ack", 64'(m_ack_o), 64'(3'b100));
    tick();
    set_s(3'd2, 1'b1, 1'b1, 32'h66);
    #1;
    check_eq("ae_err", 64'(m_err_o), 64'(3'b100));
    check_eq("ae_ack", 64'(m_ack_o), 64'(3'b000));
    tick();
    sys_rst_n = 1'b0;
    set_s(3'd2, 1'b1, 1'b0, 32'h77);
    tick();
    check_eq("rb_grant0", 64'(grant_o), 64'(3'b000));
    check_eq("rb_scyc",   64'(s_cyc_o), 64'(6'b000000));
    check_eq("rb_ack0",   64'(m_ack_o), 64'(3'b000));
    check_eq("rb_err0",   64'(m_err_o), 64'(3'b000));
    sys_rst_n = 1'b1;
    tick();
    check_eq("rb_first", 64'(grant_o), 64'(3'b001));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conbus_rr.md
Name: conbus_rr

Overview:
Parametrised successor to the fixed 6-master/6-slave shared-bus Wishbone interconnect in the SoC top.
- Generalises master count, slave count, bus widths and decode width.
- Replaces fixed-priority arbitration with registered round-robin.
- Adds a bus-error responder for unpopulated or unmapped slots and a per-transaction watchdog timeout.
- Sits between the LM32 I/D buses plus DMA-capable peripherals (e.g. TDC readout) and the BRAM, SRAM, CSR bridge and TDC slaves.

Parameters:
NM, 6, number of masters (2..8)
NS, 6, number of slave slots (1..8)
ADR_W, 32, address width
DAT_W, 32, data width; SEL_W = DAT_W/8
S_ADDR_W, 3, number of address MSBs used for decode
S_ADDR, {3'b110,3'b101,3'b100,3'b010,3'b001,3'b000}, flattened NS*S_ADDR_W slot base prefixes, slot 0 in LSBs
S_EN, 6'b111111, per-slot populated mask; a cleared bit makes the slot unmapped
TIMEOUT, 255, cycles of unacknowledged stb before an error is forced (0 disables the watchdog)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  synchronous reset, active low
m_adr_i  in  NM*ADR_W  master addresses, flattened, master 0 in LSBs
m_dat_i  in  NM*DAT_W  master write data
m_sel_i  in  NM*SEL_W  byte selects
m_cti_i  in  NM*3  cycle type
m_we_i  in  NM  write enables
m_cyc_i  in  NM  cycle
m_stb_i  in  NM  strobe
m_dat_o  out  DAT_W  read data, broadcast to all masters
m_ack_o  out  NM  acknowledge, granted master only
m_err_o  out  NM  bus error, granted master only
s_adr_o  out  ADR_W  shared slave address
s_dat_o  out  DAT_W  shared write data
s_sel_o  out  SEL_W  shared byte selects
s_cti_o  out  3  shared cycle type
s_we_o  out  1  shared write enable
s_cyc_o  out  NS  per-slave cycle
s_stb_o  out  NS  per-slave strobe
s_dat_i  in  NS*DAT_W  slave read data
s_ack_i  in  NS  slave acknowledge
s_err_i  in  NS  slave error
grant_o  out  NM  one-hot current grant (debug/perf counters)

Behaviour:
- Clocking and reset: single clock. Reset is synchronous, active low on sys_rst_n; all state is sampled on posedge sys_clk.
- Reset values: busy=0, grant index=NM-1 (so master 0 wins first), grant_o=0, watchdog=0, err pulse=0. All s_cyc_o, s_stb_o, m_ack_o and m_err_o are 0 while busy=0. s_adr_o, s_dat_o and m_dat_o carry data values only and are don't-care when idle.
- Arbitration (registered):
  - When busy=0 and any m_cyc_i is high, pick the first requesting master searching from (grant+1) mod NM upward. Latch it and set busy=1 in the next cycle.
  - The grant is held while the granted m_cyc_i stays high; CTI bursts and RMW sequences are never split.
  - When the granted m_cyc_i falls, busy drops that same edge. Re-arbitration happens in the following cycle, so there is exactly one idle cycle between owners.
  - Requests from other masters in the release cycle are considered in the next arbitration.
- Decode (combinational from granted master):
  - Compare adr[ADR_W-1 -: S_ADDR_W] against each slot.
  - The lowest-index slot that matches with S_EN set is selected.
  - s_cyc_o[k] = busy & m_cyc & hit[k]; s_stb_o[k] likewise with stb.
  - The shared outputs mux the granted master's fields.
  - m_dat_o = s_dat_i of the hit slot.
  - m_ack_o and m_err_o route s_ack_i / s_err_i of the hit slot to the granted master.
  - Latency through the interconnect is zero added cycles on the data path; only the grant is registered.
- Unmapped access (no hit): no s_cyc asserted. The error responder raises m_err_o for exactly one cycle, one cycle after stb is seen, then stays low for at least one cycle before it may respond to the next stb.
- Watchdog (TIMEOUT>0):
  - The counter increments while busy & stb & no ack/err.
  - It clears on ack, on err, or when busy falls.
  - When it reaches TIMEOUT, force m_err_o for one cycle, mask s_cyc_o/s_stb_o for that cycle, and clear the counter.
  - A late slave ack after a timeout is ignored; it is not forwarded if stb is low.
- Simultaneous ack and err from a slave: err takes precedence and ack is suppressed.
- Reset mid-transaction: on the first edge with sys_rst_n=0, busy clears. All strobes and responses are low from the following cycle, with no error pulse.

Decomposition:
- conbus_defs.vh: CTI codes (classic 000, incrementing 010, end 111) and macros for the default S_ADDR/S_EN maps shared with the SoC top.
- One sub-module, conbus_rr_arb:
  - Parametrised by NM.
  - Inputs: req[NM], release strobe.
  - Outputs: registered one-hot grant and busy.
  - Rotating-priority search.

Test Plan:
- Single master 0 reads slot 0 (adr 0x00000010), slave acks in cycle 2 -> s_cyc_o=000001, m_dat_o=slave data, m_ack_o[0] same cycle as s_ack_i[0].
- Masters 0,1,2 hold cyc continuously, each doing one access then releasing -> grant sequence 0,1,2,0, one idle cycle between grants, no master starved.
- Master 1 burst of 4 (cti 010,010,010,111) to SRAM 0x40000000 while master 0 requests -> master 0 not granted until master 1 drops cyc after the 4th ack.
- Access to 0x20000000 with S_EN bit 1 cleared -> no s_cyc_o bits, m_err_o pulses exactly one cycle, one cycle after stb.
- Slave 4 never acks, TIMEOUT=8 -> m_err_o at cycle 8 of stb, s_stb_o[4] low that cycle; a late s_ack_i is not forwarded.
- sys_rst_n driven low mid-burst -> next cycle all s_cyc_o, m_ack_o and grant_o are 0; after release, master 0 is granted first.
